// File: rtl/muldiv_pkg.sv
// Shared types for the iterative multiply/divide unit: op encoding, FSM state constants, default width.
package muldiv_pkg;

  localparam int WIDTH = 32;

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } muldiv_op_t;

  typedef logic [1:0] muldiv_state_t;
  localparam muldiv_state_t IDLE = 2'd0;
  localparam muldiv_state_t CALC = 2'd1;
  localparam muldiv_state_t DONE = 2'd2;

  function automatic logic is_mul_op(input muldiv_op_t op);
    return (op == OP_MULT) || (op == OP_MULTU);
  endfunction

  function automatic logic is_div_op(input muldiv_op_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/muldiv_addsub.sv
// Width+1-bit adder/subtractor shared by the shift-add multiply and restoring divide iterations.
module muldiv_addsub #(
  parameter int Width = 32
) (
  input  logic [Width:0] a_i,
  input  logic [Width:0] b_i,
  input  logic           sub_i,
  output logic [Width:0] sum_o,
  output logic           co_o
);

  // On subtract, co_o=1 means no borrow, i.e. a_i >= b_i.
  assign {co_o, sum_o} = {1'b0, a_i}
                       + {1'b0, b_i ^ {(Width+1){sub_i}}}
                       + {{(Width+1){1'b0}}, sub_i};

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MULT/DIV unit owning HI/LO; one add/sub step per cycle over Width cycles.
// Optional signed MULT/DIV handling is enabled with `define MULDIV_SIGNED_EN.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int Width = WIDTH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  muldiv_op_t       op_i,
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [Width-1:0] hi_o,
  output logic [Width-1:0] lo_o
);

  localparam int CntW = $clog2(Width) + 1;
  localparam logic [CntW-1:0] CntInit = CntW'(Width);

  muldiv_state_t   state_q;
  logic [CntW-1:0] cnt_q;
  logic            is_div_q;
  logic [Width-1:0] work_hi_q, work_lo_q, opnd_q;
  logic [Width-1:0] hi_q, lo_q;

  logic             start_ok;
  logic [Width-1:0] a_mag, b_mag;
  logic [Width:0]   as_a, as_b, as_sum;
  logic             as_co;
  logic [Width-1:0] it_hi, it_lo, res_hi, res_lo;

  assign start_ok = start_i & ~flush_i & (state_q == IDLE);

`ifdef MULDIV_SIGNED_EN
  logic op_sgn;
  logic neg_p_q, neg_q_q, neg_r_q;
  logic [2*Width-1:0] prod;

  assign op_sgn = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_mag  = (op_sgn & a_i[Width-1]) ? -a_i : a_i;
  assign b_mag  = (op_sgn & b_i[Width-1]) ? -b_i : b_i;
`else
  assign a_mag = a_i;
  assign b_mag = b_i;
`endif

  muldiv_addsub #(.Width(Width)) u_addsub (
    .a_i   (as_a),
    .b_i   (as_b),
    .sub_i (is_div_q),
    .sum_o (as_sum),
    .co_o  (as_co)
  );

  // Divide: shift {rem,dividend} left one and trial-subtract the divisor.
  // Multiply: add multiplicand when LSB of multiplier set, then shift {acc,mplier} right.
  always_comb begin
    as_a  = {1'b0, work_hi_q};
    as_b  = work_lo_q[0] ? {1'b0, opnd_q} : '0;
    it_hi = as_sum[Width:1];
    it_lo = {as_sum[0], work_lo_q[Width-1:1]};
    if (is_div_q) begin
      as_a  = {work_hi_q, work_lo_q[Width-1]};
      as_b  = {1'b0, opnd_q};
      it_hi = as_co ? as_sum[Width-1:0] : as_a[Width-1:0];
      it_lo = {work_lo_q[Width-2:0], as_co};
    end
  end

`ifdef MULDIV_SIGNED_EN
  always_comb begin
    prod   = neg_p_q ? -{it_hi, it_lo} : {it_hi, it_lo};
    res_hi = neg_r_q ? -prod[2*Width-1:Width] : prod[2*Width-1:Width];
    res_lo = neg_q_q ? -prod[Width-1:0]       : prod[Width-1:0];
  end
`else
  assign res_hi = it_hi;
  assign res_lo = it_lo;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      opnd_q    <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_ok) begin
            if (is_mul_op(op_i) || is_div_op(op_i)) begin
              state_q   <= CALC;
              cnt_q     <= CntInit;
              is_div_q  <= is_div_op(op_i);
              work_hi_q <= '0;
              work_lo_q <= is_div_op(op_i) ? a_mag : b_mag;
              opnd_q    <= is_div_op(op_i) ? b_mag : a_mag;
            end else if (op_i == OP_MTHI) begin
              hi_q <= a_i;
            end else if (op_i == OP_MTLO) begin
              lo_q <= a_i;
            end
          end
        end
        CALC: begin
          if (flush_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else begin
            cnt_q     <= cnt_q - 1'b1;
            work_hi_q <= it_hi;
            work_lo_q <= it_lo;
            if (cnt_q == CntW'(1)) begin
              hi_q    <= res_hi;
              lo_q    <= res_lo;
              state_q <= DONE;
            end
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef MULDIV_SIGNED_EN
  // Sign fix-up flags; a zero divisor leaves the all-ones quotient unnegated.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      neg_p_q <= 1'b0;
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
    end else if (start_ok && (is_mul_op(op_i) || is_div_op(op_i))) begin
      neg_p_q <= (op_i == OP_MULT) & (a_i[Width-1] ^ b_i[Width-1]);
      neg_q_q <= (op_i == OP_DIV) & (a_i[Width-1] ^ b_i[Width-1]) & (b_i != '0);
      neg_r_q <= (op_i == OP_DIV) & a_i[Width-1];
    end
  end
`endif

  assign busy_o = (state_q != IDLE);
  assign done_o = (state_q == DONE) & ~flush_i;
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed corners plus random ops against an arithmetic model.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W = 32;
`ifdef MULDIV_SIGNED_EN
  localparam bit SIGNED = 1'b1;
`else
  localparam bit SIGNED = 1'b0;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0, flush = 1'b0;
  muldiv_op_t   op = OP_NONE;
  logic [W-1:0] a = '0, b = '0;
  logic         busy, done;
  logic [W-1:0] hi, lo;

  muldiv_unit #(.Width(W)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .flush_i(flush), .busy_o(busy), .done_o(done), .hi_o(hi), .lo_o(lo)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_pass = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] mon_e;
  logic [W-1:0]   m_hi = '0, m_lo = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Reference: plain arithmetic on {hi,lo}
  function automatic logic [63:0] ref_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    bit sgn;
    int sx, sy, q, r;
    logic [63:0] p;
    sgn = SIGNED && (o == OP_MULT || o == OP_DIV);
    sx = int'(x);
    sy = int'(y);
    if (o == OP_MULT || o == OP_MULTU) begin
      if (sgn) p = 64'(longint'(sx) * longint'(sy));
      else     p = 64'(x) * 64'(y);
      return p;
    end
    if (y == 32'h0) return {x, 32'hFFFF_FFFF};
    if (sgn) begin
      if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
      q = sx / sy;
      r = sx % sy;
      return {32'(r), 32'(q)};
    end
    return {x % y, x / y};
  endfunction

  always @(negedge clk) begin
    if (rst_n && done) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL unexpected_done: got hi=%h lo=%h expected no done_o", hi, lo);
      end else begin
        mon_e = exp_q.pop_front();
        chk("result", {hi, lo}, mon_e);
      end
    end
  end

  task automatic wait_done(output int dc, output int bc);
    dc = 0;
    bc = 0;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      if (busy) bc++;
      if (done) begin
        dc = k;
        break;
      end
    end
  endtask

  task automatic run_op(input muldiv_op_t o, input logic [31:0] x, input logic [31:0] y);
    int dc, bc;
    @(posedge clk); #1;
    start = 1'b1; op = o; a = x; b = y;
    if (is_mul_op(o) || is_div_op(o)) begin
      exp_q.push_back(ref_op(o, x, y));
      {m_hi, m_lo} = ref_op(o, x, y);
    end else if (o == OP_MTHI) m_hi = x;
    else if (o == OP_MTLO) m_lo = x;
    @(posedge clk); #1;
    start = 1'b0; op = OP_NONE;
    if (is_mul_op(o) || is_div_op(o)) begin
      wait_done(dc, bc);
      chk("done_cycle", 64'(dc), 64'(W + 1));
      chk("busy_cycles", 64'(bc), 64'(W + 1));
    end else begin
      @(negedge clk);
      chk("mt_hi", 64'(hi), 64'(m_hi));
      chk("mt_lo", 64'(lo), 64'(m_lo));
      chk("mt_busy", 64'(busy), 64'(0));
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int dc, bc;
    muldiv_op_t ops[6];
    logic [31:0] x, y;
    ops = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO};

    #12;
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_hilo", {hi, lo}, 64'(0));
    @(posedge clk); #1 rst_n = 1'b1;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_op(OP_DIVU, 32'd100, 32'd7);
    run_op(OP_DIVU, 32'd5, 32'd0);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd5);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    run_op(OP_MTHI, 32'h0000_DEAD, 32'h0);

    // Flush mid-CALC leaves HI/LO untouched and never pulses done_o
    run_op(OP_MTHI, 32'h11, 32'h0);
    run_op(OP_MTLO, 32'h22, 32'h0);
    @(posedge clk); #1 start = 1'b1; op = OP_MULTU; a = 32'd6; b = 32'd7;
    @(posedge clk); #1 start = 1'b0; op = OP_NONE;
    repeat (8) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1 flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", 64'(busy), 64'(0));
    chk("flush_hilo", {hi, lo}, {32'h11, 32'h22});
    repeat (40) @(negedge clk);
    chk("flush_hilo_late", {hi, lo}, {32'h11, 32'h22});

    // Flush in IDLE suppresses the start
    @(posedge clk); #1 start = 1'b1; op = OP_MTHI; a = 32'h1234; flush = 1'b1;
    @(posedge clk); #1 start = 1'b0; op = OP_NONE; flush = 1'b0;
    @(negedge clk);
    chk("idle_flush_hi", 64'(hi), 64'(m_hi));

    // MTLO while busy is ignored
    @(posedge clk); #1 start = 1'b1; op = OP_MULTU; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
    exp_q.push_back(ref_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0));
    {m_hi, m_lo} = ref_op(OP_MULTU, 32'h1234_5678, 32'h9ABC_DEF0);
    @(posedge clk); #1 start = 1'b0; op = OP_NONE;
    repeat (4) @(posedge clk);
    #1 start = 1'b1; op = OP_MTLO; a = 32'hBEEF;
    @(posedge clk); #1 start = 1'b0; op = OP_NONE;
    wait_done(dc, bc);
    chk("busy_mtlo_done_seen", 64'(dc != 0), 64'(1));
    @(negedge clk);
    chk("busy_mtlo_lo", 64'(lo), 64'(m_lo));

    // Async reset mid-CALC
    @(posedge clk); #1 start = 1'b1; op = OP_MULTU; a = 32'd99; b = 32'd77;
    @(posedge clk); #1 start = 1'b0; op = OP_NONE;
    repeat (5) @(posedge clk);
    @(negedge clk); #2 rst_n = 1'b0;
    #1;
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_hilo", {hi, lo}, 64'(0));
    m_hi = '0; m_lo = '0;
    @(posedge clk); #1 rst_n = 1'b1;
    run_op(OP_MULTU, 32'd12345, 32'd6789);

    for (int i = 0; i < 30; i++) begin
      x = $urandom;
      y = $urandom;
      if ($urandom_range(0, 7) == 0) y = '0;
      if ($urandom_range(0, 7) == 0) x = 32'h8000_0000;
      if ($urandom_range(0, 7) == 0) y = 32'hFFFF_FFFF;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 15));
      run_op(ops[$urandom_range(0, 5)], x, y);
    end

    repeat (3) @(negedge clk);
    chk("queue_empty", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
